// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle integer ops with a held C/V/Z/N flag register,
// plus multi-cycle shift-add multiply and shift-by-N behind a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             single,
    input  logic [3:0]       operator,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    input  logic [3:0]       cond,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy,
    output logic             done,
    output logic             check_branch,
    output logic [1:0]       o_dbg_state
);

    // Handshake: start is taken only on a clock edge where busy is low; operands are
    // latched on that edge. done pulses for exactly one cycle when result/flags update,
    // and a new start may be presented in that same cycle.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic               r_busy;
    logic               r_done;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_sh;

    logic               w_use_c;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_neg;
    logic [CNT_W-1:0]   w_cnt;
    logic [WIDTH-1:0]   w_fres;
    logic               w_c;
    logic               w_v;
    logic               w_upd_flg;
    logic               w_upd_res;
    logic               w_go_mul;
    logic               w_go_sh;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_p_next;
    logic [WIDTH-1:0]   w_sh_next;

    assign w_use_c = r_flags[3] & ~single & ((operator == 4'd2) | (operator == 4'd3));
    assign w_add   = {1'b0, value1} + {1'b0, value2} + {{WIDTH{1'b0}}, w_use_c};
    assign w_sub   = {1'b0, value1} - {1'b0, value2} - {{WIDTH{1'b0}}, w_use_c};
    assign w_neg   = {(WIDTH+1){1'b0}} - {1'b0, value1};
    assign w_cnt   = value2[CNT_W-1:0];

    // Multiply step: conditionally add the multiplicand into the upper half, then shift right.
    assign w_madd    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_p_next  = {w_madd, r_p[WIDTH-1:1]};
    assign w_sh_next = {r_sh[WIDTH-2:0], 1'b0};

    always_comb begin
        w_fres    = r_result;
        w_c       = r_flags[3];
        w_v       = 1'b0;
        w_upd_flg = 1'b0;
        w_upd_res = 1'b0;
        w_go_mul  = 1'b0;
        w_go_sh   = 1'b0;
        if (!single) begin
            case (operator)
                4'd0, 4'd2: begin
                    w_fres    = w_add[WIDTH-1:0];
                    w_c       = w_add[WIDTH];
                    w_v       = (value1[WIDTH-1] == value2[WIDTH-1]) && (w_add[WIDTH-1] != value1[WIDTH-1]);
                    w_upd_flg = 1'b1;
                    w_upd_res = 1'b1;
                end
                4'd1, 4'd3, 4'd8: begin
                    w_fres    = w_sub[WIDTH-1:0];
                    w_c       = w_sub[WIDTH];
                    w_v       = (value1[WIDTH-1] != value2[WIDTH-1]) && (w_sub[WIDTH-1] != value1[WIDTH-1]);
                    w_upd_flg = 1'b1;
                    w_upd_res = (operator != 4'd8);
                end
                4'd4: begin w_fres = value1 & value2; w_upd_flg = 1'b1; w_upd_res = 1'b1; end
                4'd5: begin w_fres = value1 | value2; w_upd_flg = 1'b1; w_upd_res = 1'b1; end
                4'd6: begin w_fres = value1 ^ value2; w_upd_flg = 1'b1; w_upd_res = 1'b1; end
                4'd7: begin w_fres = value2;          w_upd_flg = 1'b1; w_upd_res = 1'b1; end
                4'd9: w_go_mul = 1'b1;
                default: ;
            endcase
        end else begin
            case (operator)
                4'd0: begin
                    w_fres = w_neg[WIDTH-1:0];
                    w_c    = w_neg[WIDTH];
                    w_v    = (value1 == MSB_ONLY);
                end
                4'd1: w_fres = ~value1;
                4'd2: begin w_fres = {value1[WIDTH-2:0], 1'b0};        w_c = value1[WIDTH-1]; end
                4'd3: begin w_fres = {1'b0, value1[WIDTH-1:1]};        w_c = value1[0];       end
                4'd4: w_fres = {value1[WIDTH-2:0], value1[WIDTH-1]};
                4'd5: w_fres = {value1[0], value1[WIDTH-1:1]};
                4'd6: begin w_fres = {value1[WIDTH-2:0], r_flags[3]};  w_c = value1[WIDTH-1]; end
                4'd7: begin w_fres = {r_flags[3], value1[WIDTH-1:1]};  w_c = value1[0];       end
                4'd8: begin w_fres = {value1[WIDTH-1], value1[WIDTH-1:1]}; w_c = value1[0];   end
                4'd9: w_fres = value1;
                default: ;
            endcase
            w_upd_flg = (operator <= 4'd8) || (operator == 4'd9 && w_cnt == '0);
            w_upd_res = w_upd_flg;
            w_go_sh   = (operator == 4'd9) && (w_cnt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_flags  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_p      <= '0;
            r_mcand  <= '0;
            r_sh     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_go_mul) begin
                            r_state <= ST_MUL;
                            r_busy  <= 1'b1;
                            r_p     <= {{WIDTH{1'b0}}, value2};
                            r_mcand <= value1;
                            r_cnt   <= '0;
                        end else if (w_go_sh) begin
                            r_state <= ST_SHIFT;
                            r_busy  <= 1'b1;
                            r_sh    <= value1;
                            r_cnt   <= w_cnt;
                        end else begin
                            r_done <= 1'b1;
                            if (w_upd_res) r_result <= w_fres;
                            if (w_upd_flg) r_flags  <= {w_c, w_v, (w_fres == '0), w_fres[WIDTH-1]};
                        end
                    end
                end
                ST_MUL: begin
                    r_p   <= w_p_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_p_next[WIDTH-1:0];
                        r_flags  <= {(|w_p_next[2*WIDTH-1:WIDTH]), 1'b0,
                                     (w_p_next[WIDTH-1:0] == '0), w_p_next[WIDTH-1]};
                    end
                end
                ST_SHIFT: begin
                    r_sh  <= w_sh_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state  <= ST_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_sh_next;
                        r_flags  <= {r_sh[WIDTH-1], 1'b0, (w_sh_next == '0), w_sh_next[WIDTH-1]};
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Flags are {C, V, Z, N}.
    always_comb begin
        check_branch = 1'b0;
        case (cond)
            4'd0:  check_branch = r_flags[1];
            4'd1:  check_branch = ~r_flags[1];
            4'd2:  check_branch = r_flags[0] ^ r_flags[2];
            4'd3:  check_branch = ~(r_flags[0] ^ r_flags[2]);
            4'd4:  check_branch = r_flags[3];
            4'd5:  check_branch = ~r_flags[3];
            4'd6:  check_branch = r_flags[2];
            4'd7:  check_branch = ~r_flags[2];
            4'd8:  check_branch = r_flags[0];
            4'd9:  check_branch = ~r_flags[0];
            4'd10: check_branch = r_flags[3];
            4'd11: check_branch = ~r_flags[3];
            4'd12: check_branch = 1'b1;
            default: check_branch = 1'b0;
        endcase
    end

    assign result      = r_result;
    assign flags       = r_flags;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16): hand-computed vectors checked with immediate assertions.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        single = 1'b0;
  logic [3:0]  operator = 4'd0;
  logic [15:0] value1 = 16'd0;
  logic [15:0] value2 = 16'd0;
  logic [3:0]  cond = 4'd0;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        busy;
  logic        done;
  logic        check_branch;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;
  int n_busy;
  int n_done;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .single(single), .operator(operator),
    .value1(value1), .value2(value2), .cond(cond), .result(result), .flags(flags),
    .busy(busy), .done(done), .check_branch(check_branch), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents one start for one rising edge, returns at the next falling edge.
  task automatic issue(input logic s, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    single = s; operator = op; value1 = a; value2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles with busy high, starting from the current sample; bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    // reset
    @(negedge clk); @(negedge clk);
    chk("rst_result", result, 16'h0000);
    chk("rst_flags", flags, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    reset = 1'b0;
    @(negedge clk);

    // ADD 0x7FFF + 1 -> 0x8000, C0 V1 Z0 N1
    issue(1'b0, 4'd0, 16'h7FFF, 16'h0001);
    chk("add_result", result, 16'h8000);
    chk("add_flags", flags, 4'b0101);
    chk("add_done", done, 1'b1);
    chk("add_busy", busy, 1'b0);
    cond = 4'd2; #1;
    chk("add_br_lt", check_branch, 1'b0);
    cond = 4'd8; #1;
    chk("add_br_n", check_branch, 1'b1);
    @(negedge clk);
    chk("add_done_drop", done, 1'b0);

    // SUB 0 - 1 -> 0xFFFF, C1 V0 Z0 N1
    issue(1'b0, 4'd1, 16'h0000, 16'h0001);
    chk("sub_result", result, 16'hFFFF);
    chk("sub_flags", flags, 4'b1001);
    // SBC 5 - 1 - C(1) -> 3, flags 0
    issue(1'b0, 4'd3, 16'h0005, 16'h0001);
    chk("sbc_result", result, 16'h0003);
    chk("sbc_flags", flags, 4'b0000);
    // CMP 5,5 -> Z only, result held
    issue(1'b0, 4'd8, 16'h0005, 16'h0005);
    chk("cmp_result", result, 16'h0003);
    chk("cmp_flags", flags, 4'b0010);
    cond = 4'd0; #1;
    chk("cmp_br_z", check_branch, 1'b1);
    @(negedge clk);

    // MUL 0x0123 * 0x0010 -> 0x1230, busy 16 cycles
    issue(1'b0, 4'd9, 16'h0123, 16'h0010);
    chk("mul1_no_early_done", done, 1'b0);
    count_busy(n_busy);
    chk("mul1_busy_cycles", n_busy, 16);
    chk("mul1_done", done, 1'b1);
    chk("mul1_result", result, 16'h1230);
    chk("mul1_flags", flags, 4'b0000);
    @(negedge clk);
    // MUL 0x0100 * 0x0100 -> low 0, high nonzero: C1 Z1
    issue(1'b0, 4'd9, 16'h0100, 16'h0100);
    count_busy(n_busy);
    chk("mul2_busy_cycles", n_busy, 16);
    chk("mul2_result", result, 16'h0000);
    chk("mul2_flags", flags, 4'b1010);
    @(negedge clk);

    // LSLN 1 by 15 -> 0x8000, C0 N1, latency 15, with an ignored mid-op start
    issue(1'b1, 4'd9, 16'h0001, 16'd15);
    n_busy = 0;
    n_done = 0;
    while (busy && n_busy < 100) begin
      n_busy++;
      if (done) n_done++;
      if (n_busy == 5) begin
        single = 1'b0; operator = 4'd0; value1 = 16'h0001; value2 = 16'h0001; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("lsln_busy_cycles", n_busy, 15);
    chk("lsln_result", result, 16'h8000);
    chk("lsln_flags", flags, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    chk("lsln_one_done", n_done, 1);
    chk("lsln_result_held", result, 16'h8000);

    // Reset five cycles into a MUL aborts without a done
    issue(1'b0, 4'd9, 16'h0003, 16'h0004);
    repeat (4) @(negedge clk);
    chk("abort_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_result", result, 16'h0000);
    chk("abort_flags", flags, 4'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done || busy) n_done++;
      @(negedge clk);
    end
    chk("abort_quiet", n_done, 0);
    issue(1'b0, 4'd0, 16'h0002, 16'h0003);
    chk("post_add_result", result, 16'h0005);
    chk("post_add_done", done, 1'b1);

    // Back-to-back: ROR 1 -> 0x8000 (C stays 0), then RRC 1 in the done cycle -> 0, C1 Z1
    issue(1'b1, 4'd5, 16'h0001, 16'h0000);
    chk("ror_result", result, 16'h8000);
    chk("ror_flags", flags, 4'b0001);
    chk("ror_done", done, 1'b1);
    issue(1'b1, 4'd7, 16'h0001, 16'h0000);
    chk("rrc_result", result, 16'h0000);
    chk("rrc_flags", flags, 4'b1010);
    chk("rrc_done", done, 1'b1);
    cond = 4'd4; #1;
    chk("rrc_br_c", check_branch, 1'b1);
    cond = 4'd5; #1;
    chk("rrc_br_nc", check_branch, 1'b0);
    cond = 4'd12; #1;
    chk("br_always", check_branch, 1'b1);
    cond = 4'd13; #1;
    chk("br_never", check_branch, 1'b0);
    @(negedge clk);

    // Undefined opcode: done pulses, result and flags held
    issue(1'b0, 4'd12, 16'h1234, 16'h5678);
    chk("undef_done", done, 1'b1);
    chk("undef_result", result, 16'h0000);
    chk("undef_flags", flags, 4'b1010);

    // NEG of MSB-only value: V1, C1 (borrow), N1
    issue(1'b1, 4'd0, 16'h8000, 16'h0000);
    chk("neg_result", result, 16'h8000);
    chk("neg_flags", flags, 4'b1101);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the CPU's single-cycle ALU: two-operand and single-operand integer operations on WIDTH-bit data, held C/V/Z/N flag register, branch-condition evaluation, and multi-cycle operations (shift-and-add multiply, shift-by-N) behind a start/busy/done handshake. Sits in the execute stage between the register-file read ports and the write-back mux. The control FSM holds issue while `busy` is high.

## Interface
- WIDTH, 16, data width in bits; must be ≥ 4.
- CNT_W, $clog2(WIDTH), width of the iteration counter and of the shift-count field.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue request; sampled only when `busy` = 0.
- single  in  1  1 selects the single-operand opcode set; 0 selects the two-operand set.
- operator  in  4  opcode.
- value1, value2  in  WIDTH  operands, latched when `start` is accepted.
- cond  in  4  branch condition code.
- result  out  WIDTH  registered result.
- flags  out  4  registered {C, V, Z, N}.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse when `result` and `flags` are updated.
- check_branch  out  1  combinational branch decision from `flags` and `cond`.

## Operation
- Two-operand opcodes (single=0):
  - 0 ADD, 1 SUB, 2 ADC, 3 SBC, 4 AND, 5 OR, 6 XOR, 7 MOV (result = value2).
  - 8 CMP: SUB flags, `result` unchanged.
  - 9 MUL: low WIDTH bits of the product.
- Single-operand opcodes (single=1):
  - 0 NEG (0 − v1), 1 COM (~v1).
  - 2 LSL, 3 LSR, 4 ROL, 5 ROR.
  - 6 RLC, 7 RRC: rotate through C.
  - 8 ASR.
  - 9 LSLN: shift v1 left by value2[CNT_W-1:0].
- Arithmetic is WIDTH+1 bits wide; C is the bit WIDTH carry.
  - SUB/SBC/CMP/NEG: C = borrow.
  - ADC adds C; SBC subtracts C.
- Carry rules for other ops:
  - Shifts: C = last bit shifted out. LSLN with count 0: C unchanged.
  - ROL/ROR: C unchanged.
  - MUL: C = 1 iff the high half of the product is non-zero.
  - AND/OR/XOR/MOV/COM: C unchanged.
- V is signed overflow:
  - ADD/ADC: operands have the same sign and the result sign differs.
  - SUB/SBC/CMP: operand signs differ and the result sign differs from v1.
  - NEG: v1 == MSB-only value.
  - All other ops: V = 0.
- Z = (result == 0) and N = result[WIDTH-1] on every flag-updating op.
- Undefined opcode: `result` and `flags` unchanged, `done` still pulses.
- FSM states:
  - IDLE: accept `start`. Single-cycle ops complete at the next edge and return to IDLE. MUL → MUL. LSLN with count > 0 → SHIFT.
  - MUL: one shift-add step per cycle, WIDTH steps, then IDLE.
  - SHIFT: one bit per cycle, count steps, then IDLE.
- `start` while `busy` = 1 is ignored; no queueing.
- check_branch by `cond`:
  - 0 Z, 1 ~Z.
  - 2 N^V, 3 ~(N^V).
  - 4 C, 5 ~C.
  - 6 V, 7 ~V.
  - 8 N, 9 ~N.
  - 10 C (LO), 11 ~C (SH).
  - 12 always 1; 13–15 give 0.

## Timing
- Reset values: result = 0, flags = 0, busy = 0, done = 0, FSM = IDLE, counter = 0.
- Reset wins over `start` in the same cycle.
- Reset mid-operation aborts; no `done` is produced.
- Single-cycle op, `start` sampled at edge E0:
  - `result`/`flags` valid after E0.
  - `done` = 1 for that cycle only.
  - `busy` stays 0.
- MUL:
  - `busy` = 1 from E0 through edge E_WIDTH.
  - Result, flags and `done` appear after E_WIDTH, with `busy` = 0 in the same cycle.
  - Latency = WIDTH cycles.
- LSLN with count n > 0: same pattern, latency n. With n = 0 it behaves as a single-cycle op (result = v1).
- A new `start` is accepted in the same cycle `done` is high, giving back-to-back issue.
- `check_branch` follows `flags` combinationally, so it reflects the new flags in the `done` cycle.
- Mid-op operand changes have no effect; operands were latched at accept.

## Test plan
- WIDTH=16, ADD 0x7FFF + 0x0001 → result 0x8000, flags C=0 V=1 Z=0 N=1, `done` 1 cycle after `start`, `busy` never high. Then cond=2 (BRLT) gives 0 and cond=8 gives 1.
- SUB 0x0000 − 0x0001 → 0xFFFF with C=1 N=1. Follow with SBC 0x0005 − 0x0001 → 0x0003 with C=0. Then CMP 5,5 → Z=1 with `result` still 0x0003, and cond=0 gives 1.
- MUL 0x0123 × 0x0010 → 0x1230, C=0, `busy` high exactly 16 cycles. Then MUL 0x0100 × 0x0100 → 0x0000 with C=1 Z=1.
- LSLN 0x0001 by 15 → 0x8000, C=0, N=1, latency 15. A `start` pulsed mid-operation is ignored: result unchanged and exactly one `done`.
- Reset asserted 5 cycles into a MUL → all outputs 0 next cycle, no `done`. A following ADD 2+3 returns 0x0005 one cycle after `start`.
- Back-to-back issue: ROR 0x0001 → 0x8000 with C unchanged, immediately followed in the `done` cycle by RRC on 0x0001 → result 0x0000 with C=1, Z=1.
